fop_sweep_ctrl: RTL and testbench
=================================

Name: fop_sweep_ctrl

Overview:
Self-check sequencer for the 4-bit fop function block. It sweeps the shared 4-bit input through all 16 codes and drives the gate, dataflow and behavioural implementations (G/D/B) in parallel. For each code it samples the three outputs and checks them against each other and against a golden truth mask. It then reports an error count, a per-code fail bitmap, the first failing code and a pass flag. It is the on-chip replacement for the manual sweep bench and sits between a start strobe and the three fop instances.

Parameters:
SETTLE, 2, number of wait cycles `fop_in` is held before outputs are sampled (0..15 legal; 0 = sample in the first cycle the code is driven)
GOLDEN, 16'h29AF, expected output per code, bit i = expected out for in=i (1 for codes 0,1,2,3,5,7,8,11,13)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE or DONE
abort  input  1  stop the sweep and return to IDLE; priority over start
out_g  input  1  fop_G output
out_d  input  1  fop_D output
out_b  input  1  fop_B output
fop_in  output  4  code driven to all three fop instances
busy  output  1  high in WAIT and CHECK
done  output  1  high in DONE; held until the next start or abort
pass  output  1  valid while done: 1 iff err_cnt==0
err_cnt  output  5  number of failing codes (0..16)
fail_map  output  16  bit i set if code i failed
first_err  output  4  lowest failing code; 0 if none
err_pulse  output  1  one-cycle strobe in a CHECK cycle that fails

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; fop_in=0; busy=0; done=0; pass=0; err_cnt=0; fail_map=0; first_err=0; err_pulse=0; wait counter=0.
  - Reset mid-sweep discards all results immediately.
- FSM states:
  - IDLE
    - start=1 → clear err_cnt, fail_map, first_err and pass; idx=0; fop_in=0.
    - Next state is WAIT with cnt=SETTLE-1 if SETTLE>0, else CHECK.
  - WAIT
    - fop_in held stable.
    - cnt==0 → CHECK; otherwise cnt decrements.
  - CHECK (exactly 1 cycle)
    - mismatch = (out_g!=out_d) | (out_d!=out_b) | (out_g!=GOLDEN[idx]).
    - On mismatch:
      - err_cnt+1 (registered);
      - fail_map[idx]=1;
      - err_pulse=1 this cycle (combinational from sampled inputs, or registered to the next cycle; chosen form documented in RTL, bench accepts the same cycle);
      - first_err=idx if err_cnt was 0.
    - idx==15 → DONE.
    - Otherwise idx+1, fop_in=idx+1, then WAIT/CHECK per the SETTLE rule above.
  - DONE
    - done=1; pass=(err_cnt==0).
    - start=1 → clear results, same action as in IDLE.
- abort=1 in any state → IDLE next cycle:
  - done=0, busy=0, fop_in=0;
  - err_cnt, fail_map and first_err are retained (debug);
  - pass=0.
- start while busy: ignored.
- start and abort together: abort wins.
- Timing:
  - Each code occupies SETTLE+1 cycles.
  - done rises 16*(SETTLE+1) cycles after the start-accept edge; 48 cycles at the default.
- fop_in changes only on the cycle after a CHECK, so the three instances always see a stable code for SETTLE+1 cycles.
- Width rules:
  - idx is a 4-bit counter, terminated explicitly at 15 (no wrap to 0 within a sweep).
  - err_cnt is 5 bits and reaches at most 16, so it cannot overflow.
- All outputs are registered except err_pulse.

Test Plan:
- Correct fop models, SETTLE=2, pulse start → fop_in steps 0..15 every 3 cycles; done=1 at cycle 48; pass=1; err_cnt=0; fail_map=16'h0000; err_pulse never high.
- out_b forced to 0 → failures at golden-1 codes {0,1,2,3,5,7,8,11,13}: err_cnt=9; fail_map=16'h29AF; first_err=0; pass=0.
- out_d inverted only when fop_in==4'd6 → err_cnt=1; fail_map=16'h0040; first_err=6; one err_pulse during the CHECK of code 6.
- abort asserted while fop_in==4'd9 → IDLE next cycle, busy=0, done=0, fop_in=0. A following start runs a clean full sweep with pass=1.
- rst asserted mid-sweep, asynchronously between clock edges → all outputs go to 0 immediately. start is ignored while busy; start in DONE restarts the sweep with results cleared.
- SETTLE=0 → one cycle per code; done 16 cycles after start; results identical to the first scenario.

Source files
------------

// File: rtl/fop_sweep_ctrl.sv
// Self-check sequencer for the fop block: sweeps all 16 input codes, compares the
// G/D/B outputs with each other and with a golden mask, and reports the results.
module fop_sweep_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter logic [15:0] GOLDEN = 16'h29AF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        out_g,
    input  logic        out_d,
    input  logic        out_b,
    output logic [3:0]  fop_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [15:0] fail_map,
    output logic [3:0]  first_err,
    output logic        err_pulse
);

    typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

    localparam logic [3:0] CntInit = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  err_cnt_q, err_cnt_d;
    logic [15:0] fail_map_q, fail_map_d;
    logic [3:0]  first_err_q, first_err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        accept;
    logic        mismatch;
    logic        check_fail;

    assign accept     = start && !abort && ((state_q == StIdle) || (state_q == StDone));
    assign mismatch   = (out_g != out_d) || (out_d != out_b) || (out_g != GOLDEN[idx_q]);
    // An abort landing on a CHECK cycle wins: that code is neither recorded nor pulsed.
    assign check_fail = (state_q == StCheck) && !abort && mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = StIdle;
            idx_d   = 4'd0;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        idx_d = 4'd0;
                        if (SETTLE > 0) begin
                            state_d = StWait;
                            cnt_d   = CntInit;
                        end else begin
                            state_d = StCheck;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StCheck: begin
                    if (idx_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (SETTLE > 0) begin
                            state_d = StWait;
                            cnt_d   = CntInit;
                        end else begin
                            state_d = StCheck;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        err_cnt_d   = err_cnt_q;
        fail_map_d  = fail_map_q;
        first_err_d = first_err_q;
        if (accept) begin
            err_cnt_d   = 5'd0;
            fail_map_d  = 16'd0;
            first_err_d = 4'd0;
        end else if (check_fail) begin
            err_cnt_d  = err_cnt_q + 5'd1;
            fail_map_d = fail_map_q | (16'd1 << idx_q);
            if (err_cnt_q == 5'd0) begin
                first_err_d = idx_q;
            end
        end
        busy_d = (state_d == StWait) || (state_d == StCheck);
        done_d = (state_d == StDone);
        pass_d = done_d && (err_cnt_d == 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= 4'd0;
            cnt_q       <= 4'd0;
            err_cnt_q   <= 5'd0;
            fail_map_q  <= 16'd0;
            first_err_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_cnt_q   <= err_cnt_d;
            fail_map_q  <= fail_map_d;
            first_err_q <= first_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // idx is registered and always equals the code currently being driven.
    assign fop_in    = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_map  = fail_map_q;
    assign first_err = first_err_q;
    // Combinational: asserted in the failing CHECK cycle itself.
    assign err_pulse = check_fail;

endmodule

// File: tb/tb_fop_sweep_ctrl.sv
// Randomized self-checking bench for fop_sweep_ctrl; two instances cover SETTLE=2 and
// SETTLE=0, each fed by a behavioural fop model with injectable faults.
module tb_fop_sweep_ctrl;

    localparam logic [15:0] Golden = 16'h29AF;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic        g2, d2, b2, g0, d0, b0;
    logic [3:0]  fop_in, fop_in0, first_err, first_err0;
    logic        busy, busy0, done, done0, pass, pass0, err_pulse, err_pulse0;
    logic [4:0]  err_cnt, err_cnt0;
    logic [15:0] fail_map, fail_map0;

    int          fmode = 0;
    int          fsig = 0;
    logic [15:0] fmask = 16'd0;
    int          pass_cnt = 0;
    int          total = 0;
    logic        pclr = 1'b0;
    int          pcnt2 = 0, pcnt0 = 0;
    logic [15:0] pmap2 = 16'd0, pmap0 = 16'd0;

    always #5 clk = ~clk;

    fop_sweep_ctrl #(.SETTLE(2), .GOLDEN(Golden)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .out_g(g2), .out_d(d2), .out_b(b2), .fop_in(fop_in), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_map(fail_map), .first_err(first_err),
        .err_pulse(err_pulse)
    );

    fop_sweep_ctrl #(.SETTLE(0), .GOLDEN(Golden)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .out_g(g0), .out_d(d0), .out_b(b0), .fop_in(fop_in0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(err_cnt0), .fail_map(fail_map0), .first_err(first_err0),
        .err_pulse(err_pulse0)
    );

    // fop model {g,d,b}: mode 1 sticks b at 0, mode 2 inverts one output on masked codes.
    function automatic logic [2:0] outs(input logic [3:0] c, input int mode,
                                        input logic [15:0] mask, input int sig);
        logic [15:0] gm;
        logic [2:0]  o;
        gm = Golden;
        o  = {3{gm[c]}};
        if (mode == 1) o[0] = 1'b0;
        else if (mode == 2 && mask[c]) o[2-sig] = ~o[2-sig];
        return o;
    endfunction

    always @* {g2, d2, b2} = outs(fop_in, fmode, fmask, fsig);
    always @* {g0, d0, b0} = outs(fop_in0, fmode, fmask, fsig);

    always @(negedge clk) begin
        if (pclr) begin
            pcnt2 = 0; pmap2 = 16'd0; pcnt0 = 0; pmap0 = 16'd0;
        end else begin
            if (err_pulse)  begin pcnt2++; pmap2[fop_in] = 1'b1; end
            if (err_pulse0) begin pcnt0++; pmap0[fop_in0] = 1'b1; end
        end
    end

    // Starts a sweep and follows it until done; checks the code/busy timeline on the way.
    task automatic run_sweep(input bit sel0, input int restart_at,
                             output int lat, output int trace_err);
        int per;
        per = sel0 ? 1 : 3;
        pclr = 1'b1;
        @(negedge clk);
        #1 pclr = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        trace_err = 0;
        while (lat < 300) begin
            if (sel0 ? done0 : done) break;
            if ((sel0 ? fop_in0 : fop_in) != 4'(lat / per)) trace_err++;
            if (!(sel0 ? busy0 : busy)) trace_err++;
            start = (lat == restart_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic model(output logic [4:0] ecnt, output logic [15:0] emap,
                         output logic [3:0] efirst);
        logic [2:0]  o;
        logic [15:0] gm;
        gm = Golden;
        emap = 16'd0;
        ecnt = 5'd0;
        efirst = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            o = outs(4'(i), fmode, fmask, fsig);
            if (o[2] != o[1] || o[1] != o[0] || o[2] != gm[i]) begin
                emap[i] = 1'b1;
                ecnt++;
                efirst = 4'(i);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        #1;
        total++; if ({fop_in, busy, done, pass, err_cnt, fail_map, first_err, err_pulse} !== 33'd0)
            $display("FAIL reset_outputs got %h want 0",
                     {fop_in, busy, done, pass, err_cnt, fail_map, first_err, err_pulse});
        else pass_cnt++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if ({busy, done, busy0, done0} !== 4'd0)
            $display("FAIL idle_after_reset got %b want 0000", {busy, done, busy0, done0});
        else pass_cnt++;
    endtask

    task automatic test_clean;
        int lat, terr;
        fmode = 0;
        run_sweep(1'b0, -1, lat, terr);
        total++; if (lat !== 48) $display("FAIL clean_latency got %0d want 48", lat);
        else pass_cnt++;
        total++; if (terr !== 0) $display("FAIL clean_trace got %0d bad samples want 0", terr);
        else pass_cnt++;
        total++; if ({pass, err_cnt, fail_map, first_err} !== {1'b1, 25'd0})
            $display("FAIL clean_results got %h want %h", {pass, err_cnt, fail_map, first_err},
                     {1'b1, 25'd0});
        else pass_cnt++;
        total++; if (pcnt2 !== 0) $display("FAIL clean_pulses got %0d want 0", pcnt2);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        total++; if ({done, pass, busy} !== 3'b110)
            $display("FAIL done_held got %b want 110", {done, pass, busy});
        else pass_cnt++;
    endtask

    task automatic test_stuck_b;
        int lat, terr;
        fmode = 1;
        run_sweep(1'b0, -1, lat, terr);
        total++; if ({err_cnt, fail_map, first_err, pass} !== {5'd9, 16'h29AF, 4'd0, 1'b0})
            $display("FAIL stuck_b got %h want %h", {err_cnt, fail_map, first_err, pass},
                     {5'd9, 16'h29AF, 4'd0, 1'b0});
        else pass_cnt++;
        total++; if (pmap2 !== 16'h29AF) $display("FAIL stuck_b_pulses got %h want 29af", pmap2);
        else pass_cnt++;
    endtask

    task automatic test_code6;
        int lat, terr;
        fmode = 2; fsig = 1; fmask = 16'h0040;
        run_sweep(1'b0, -1, lat, terr);
        total++; if ({err_cnt, fail_map, first_err, pass} !== {5'd1, 16'h0040, 4'd6, 1'b0})
            $display("FAIL code6 got %h want %h", {err_cnt, fail_map, first_err, pass},
                     {5'd1, 16'h0040, 4'd6, 1'b0});
        else pass_cnt++;
        total++; if ({pcnt2[3:0], pmap2} !== {4'd1, 16'h0040})
            $display("FAIL code6_pulse got %h want 10040", {pcnt2[3:0], pmap2});
        else pass_cnt++;
    endtask

    task automatic test_random;
        int lat, terr;
        logic [4:0]  ecnt;
        logic [15:0] emap;
        logic [3:0]  efirst;
        for (int it = 0; it < 6; it++) begin
            fmode = 2;
            fsig  = $urandom_range(0, 2);
            fmask = 16'($urandom) & 16'($urandom | 32'h1111);
            model(ecnt, emap, efirst);
            run_sweep(1'b0, -1, lat, terr);
            total++;
            if ({err_cnt, fail_map, first_err, pass, pmap2} !==
                {ecnt, emap, efirst, ecnt == 5'd0, emap})
                $display("FAIL random_%0d got %h want %h", it,
                         {err_cnt, fail_map, first_err, pass, pmap2},
                         {ecnt, emap, efirst, ecnt == 5'd0, emap});
            else pass_cnt++;
        end
    endtask

    task automatic test_abort;
        int lat, terr, k;
        fmode = 2; fsig = 0; fmask = 16'h0006;
        pclr = 1'b1;
        @(negedge clk);
        #1 pclr = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (fop_in != 4'd9 && k < 100) begin @(negedge clk); k++; end
        total++; if (k >= 100) $display("FAIL abort_wait got timeout want fop_in 9");
        else pass_cnt++;
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        total++;
        if ({busy, done, pass, fop_in, err_cnt, fail_map, first_err} !==
            {3'b000, 4'd0, 5'd2, 16'h0006, 4'd1})
            $display("FAIL abort_state got %h want %h",
                     {busy, done, pass, fop_in, err_cnt, fail_map, first_err},
                     {3'b000, 4'd0, 5'd2, 16'h0006, 4'd1});
        else pass_cnt++;
        fmode = 0;
        run_sweep(1'b0, -1, lat, terr);
        total++; if ({lat[7:0], pass, err_cnt} !== {8'd48, 1'b1, 5'd0})
            $display("FAIL after_abort got %h want %h", {lat[7:0], pass, err_cnt},
                     {8'd48, 1'b1, 5'd0});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat, terr;
        fmode = 2; fsig = 2; fmask = 16'h8001;
        run_sweep(1'b0, -1, lat, terr);
        total++; if ({err_cnt, first_err} !== {5'd2, 4'd0})
            $display("FAIL b2b_first got %h want 20", {err_cnt, first_err});
        else pass_cnt++;
        // Restart from DONE with a clean model; a start mid-sweep must be ignored.
        fmode = 0;
        run_sweep(1'b0, 10, lat, terr);
        total++; if ({lat[7:0], terr[7:0]} !== {8'd48, 8'd0})
            $display("FAIL start_while_busy got lat %0d bad %0d want 48 0", lat, terr);
        else pass_cnt++;
        total++; if ({pass, err_cnt, fail_map, first_err} !== {1'b1, 25'd0})
            $display("FAIL restart_cleared got %h want %h",
                     {pass, err_cnt, fail_map, first_err}, {1'b1, 25'd0});
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        fmode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({fop_in, busy, done, pass, err_cnt, fail_map, first_err, err_pulse,
             fop_in0, busy0, done0, err_cnt0, fail_map0} !== 63'd0)
            $display("FAIL async_reset got %h want 0",
                     {fop_in, busy, done, pass, err_cnt, fail_map, first_err, err_pulse,
                      fop_in0, busy0, done0, err_cnt0, fail_map0});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_settle0;
        int lat, terr;
        logic [4:0]  ecnt;
        logic [15:0] emap;
        logic [3:0]  efirst;
        fmode = 0;
        run_sweep(1'b1, -1, lat, terr);
        total++; if ({lat[7:0], terr[7:0]} !== {8'd16, 8'd0})
            $display("FAIL settle0_timing got lat %0d bad %0d want 16 0", lat, terr);
        else pass_cnt++;
        total++; if ({pass0, err_cnt0, fail_map0, first_err0, pcnt0[3:0]} !== {1'b1, 29'd0})
            $display("FAIL settle0_clean got %h want %h",
                     {pass0, err_cnt0, fail_map0, first_err0, pcnt0[3:0]}, {1'b1, 29'd0});
        else pass_cnt++;
        fmode = 2; fsig = $urandom_range(0, 2); fmask = 16'($urandom) | 16'h0100;
        model(ecnt, emap, efirst);
        run_sweep(1'b1, -1, lat, terr);
        total++;
        if ({err_cnt0, fail_map0, first_err0, pass0, pmap0} !== {ecnt, emap, efirst, 1'b0, emap})
            $display("FAIL settle0_random got %h want %h",
                     {err_cnt0, fail_map0, first_err0, pass0, pmap0},
                     {ecnt, emap, efirst, 1'b0, emap});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuck_b();
        test_code6();
        test_random();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_settle0();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
